// File: rtl/slowframe_rx.sv
// Receive parser for host slow-down request frames: pulses HostRequestSlowDown and latches the fill amount.
// Optional accept/drop statistics counters are enabled by defining RVVI_SLOWFRAME_STATS_EN.
module slowframe_rx #(
   parameter logic [47:0] DEST_MAC     = 48'h02_00_00_00_00_01,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] ETH_TYPE     = 16'h88B5,
   parameter logic [15:0] SLOW_OPCODE  = 16'h534C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   input  logic        RxLast,
   input  logic        RxError,
   output logic        HostRequestSlowDown,
   output logic [31:0] HostFiFoFillAmt,
   output logic [15:0] FramesAccepted,
   output logic [15:0] FramesDropped
);

   typedef enum logic [2:0] {
      STATE_IDLE, STATE_HDR, STATE_PAYLOAD, STATE_DRAIN, STATE_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        ucast_q, ucast_d, bcast_q, bcast_d, type_ok_q, type_ok_d, err_q, err_d;
   logic [31:0] hold_q, hold_d, fill_q, fill_d;
   logic        pulse_q, pulse_d;
   logic [4:0]  cur_idx_s;
   logic        err_s, opc_bad_s, accept_s, drop_s;

   function automatic logic [7:0] dest_byte(input logic [4:0] idx);
      case (idx)
         5'd0:    return DEST_MAC[47:40];
         5'd1:    return DEST_MAC[39:32];
         5'd2:    return DEST_MAC[31:24];
         5'd3:    return DEST_MAC[23:16];
         5'd4:    return DEST_MAC[15:8];
         5'd5:    return DEST_MAC[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Per-beat parse: field matching, state transitions and accept/drop decision.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ucast_d   = ucast_q;
      bcast_d   = bcast_q;
      type_ok_d = type_ok_q;
      err_d     = err_q;
      hold_d    = hold_q;
      accept_s  = 1'b0;
      drop_s    = 1'b0;
      cur_idx_s = (state_q == STATE_IDLE) ? 5'd0 : idx_q;
      err_s     = ((state_q == STATE_IDLE) ? 1'b0 : err_q) | RxError;
      opc_bad_s = ((cur_idx_s == 5'd14) && (RxData != SLOW_OPCODE[15:8])) ||
                  ((cur_idx_s == 5'd15) && (RxData != SLOW_OPCODE[7:0]));
      if (RxValid) begin
         err_d = err_s;
         idx_d = (cur_idx_s < 5'd20) ? cur_idx_s + 5'd1 : 5'd20;
         if (cur_idx_s < 5'd6) begin
            ucast_d = ((state_q == STATE_IDLE) ? 1'b1 : ucast_q) & (RxData == dest_byte(cur_idx_s));
            bcast_d = ((state_q == STATE_IDLE) ? ACCEPT_BCAST : bcast_q) & (RxData == 8'hFF);
         end else begin
            ucast_d = ucast_q;
            bcast_d = bcast_q;
         end
         if (cur_idx_s == 5'd12) begin
            type_ok_d = (RxData == ETH_TYPE[15:8]);
         end else if (cur_idx_s == 5'd13) begin
            type_ok_d = type_ok_q & (RxData == ETH_TYPE[7:0]);
         end else begin
            type_ok_d = type_ok_q;
         end
         if ((cur_idx_s >= 5'd16) && (cur_idx_s <= 5'd19)) begin
            hold_d = {hold_q[23:0], RxData};
         end else begin
            hold_d = hold_q;
         end
         case (state_q)
            STATE_IDLE: begin
               if (RxLast) drop_s = 1'b1;
               else        state_d = STATE_HDR;
            end
            STATE_HDR: begin
               if (RxLast) begin
                  drop_s = 1'b1;
               end else if (cur_idx_s == 5'd13) begin
                  state_d = ((ucast_d | bcast_d) & type_ok_d) ? STATE_PAYLOAD : STATE_DROP;
               end else begin
                  state_d = STATE_HDR;
               end
            end
            STATE_PAYLOAD: begin
               // A frame ending exactly on the last fill byte is still complete.
               if (RxLast) begin
                  accept_s = (cur_idx_s == 5'd19) & ~err_s;
                  drop_s   = ~accept_s;
               end else if (opc_bad_s) begin
                  state_d = STATE_DROP;
               end else if (cur_idx_s == 5'd19) begin
                  state_d = STATE_DRAIN;
               end else begin
                  state_d = STATE_PAYLOAD;
               end
            end
            STATE_DRAIN: begin
               if (RxLast) begin
                  accept_s = ~err_s;
                  drop_s   = err_s;
               end else begin
                  state_d = STATE_DRAIN;
               end
            end
            STATE_DROP: begin
               if (RxLast) drop_s = 1'b1;
               else        state_d = STATE_DROP;
            end
            default: state_d = STATE_IDLE;
         endcase
         if (RxLast) begin
            state_d = STATE_IDLE;
            idx_d   = 5'd0;
            err_d   = 1'b0;
         end else begin
            err_d   = err_s;
         end
      end else begin
         idx_d = idx_q;
      end
      pulse_d = accept_s;
      fill_d  = accept_s ? hold_d : fill_q;
   end

   // Parser state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= STATE_IDLE;
         idx_q     <= 5'd0;
         ucast_q   <= 1'b0;
         bcast_q   <= 1'b0;
         type_ok_q <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= 32'h0000_0000;
         fill_q    <= 32'h0000_0000;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ucast_q   <= ucast_d;
         bcast_q   <= bcast_d;
         type_ok_q <= type_ok_d;
         err_q     <= err_d;
         hold_q    <= hold_d;
         fill_q    <= fill_d;
         pulse_q   <= pulse_d;
      end
   end

   assign HostRequestSlowDown = pulse_q;
   assign HostFiFoFillAmt     = fill_q;

`ifdef RVVI_SLOWFRAME_STATS_EN
   logic [15:0] acc_q, acc_d, drp_q, drp_d;

   // Saturating statistics counter next values.
   always_comb begin
      acc_d = acc_q;
      drp_d = drp_q;
      if (accept_s && (acc_q != 16'hFFFF)) acc_d = acc_q + 16'd1;
      else                                 acc_d = acc_q;
      if (drop_s && (drp_q != 16'hFFFF))   drp_d = drp_q + 16'd1;
      else                                 drp_d = drp_q;
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= 16'h0000;
         drp_q <= 16'h0000;
      end else begin
         acc_q <= acc_d;
         drp_q <= drp_d;
      end
   end

   assign FramesAccepted = acc_q;
   assign FramesDropped  = drp_q;
`else
   assign FramesAccepted = 16'h0000;
   assign FramesDropped  = 16'h0000;
`endif

endmodule

// File: tb/tb_slowframe_rx.sv
// Directed bench for slowframe_rx; a second instance with ACCEPT_BCAST=0 covers broadcast rejection.
module tb_slowframe_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  RxData;
   logic        RxValid, RxLast, RxError;
   logic        pulse_s, nb_pulse_s;
   logic [31:0] fill_s, nb_fill_s;
   logic [15:0] acc_s, drp_s, nb_acc_s, nb_drp_s;

   int n_total = 0;
   int n_bad   = 0;
   int exp_acc = 0, exp_drp = 0, nb_exp_acc = 0, nb_exp_drp = 0;
   logic [7:0] fb [0:99];

   always #5 clk = ~clk;

   slowframe_rx dut (
      .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid), .RxLast(RxLast),
      .RxError(RxError), .HostRequestSlowDown(pulse_s), .HostFiFoFillAmt(fill_s),
      .FramesAccepted(acc_s), .FramesDropped(drp_s)
   );

   slowframe_rx #(.ACCEPT_BCAST(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid), .RxLast(RxLast),
      .RxError(RxError), .HostRequestSlowDown(nb_pulse_s), .HostFiFoFillAmt(nb_fill_s),
      .FramesAccepted(nb_acc_s), .FramesDropped(nb_drp_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int v);
`ifdef RVVI_SLOWFRAME_STATS_EN
      return v;
`else
      return 32'h0000_0000;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build(input logic [47:0] dest, input logic [15:0] et, input logic [15:0] op,
                        input logic [31:0] fill);
      logic [47:0] src;
      src = 48'h0A_0B_0C_0D_0E_0F;
      for (int i = 0; i < 100; i++) fb[i] = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         fb[i]     = dest[47-8*i -: 8];
         fb[6 + i] = src[47-8*i -: 8];
      end
      fb[12] = et[15:8];   fb[13] = et[7:0];
      fb[14] = op[15:8];   fb[15] = op[7:0];
      fb[16] = fill[31:24]; fb[17] = fill[23:16]; fb[18] = fill[15:8]; fb[19] = fill[7:0];
   endtask

   // Gap cycles drive garbage with RxLast/RxError high to prove RxValid gating.
   task automatic send(input int from, input int to, input bit do_last, input int err_idx, input int gap);
      for (int i = from; i <= to; i++) begin
         RxValid = 1'b1; RxData = fb[i];
         RxLast  = do_last && (i == to);
         RxError = (i == err_idx);
         tick();
         if (i == from) chk("pulse_clear", {31'd0, pulse_s}, 32'd0);
         if (gap > 0 && i != to && (i % 7) == 3) begin
            for (int g = 0; g < gap; g++) begin
               RxValid = 1'b0; RxData = 8'hFF; RxLast = 1'b1; RxError = 1'b1;
               tick();
            end
         end
      end
      RxValid = 1'b0; RxLast = 1'b0; RxError = 1'b0; RxData = 8'h00;
   endtask

   task automatic check_end(input bit p, input logic [31:0] f, input bit nbp, input logic [31:0] nbf);
      chk("pulse", {31'd0, pulse_s}, {31'd0, p});
      chk("fill", fill_s, f);
      chk("nb_pulse", {31'd0, nb_pulse_s}, {31'd0, nbp});
      chk("nb_fill", nb_fill_s, nbf);
      chk("accepted", {16'd0, acc_s}, cnt(exp_acc));
      chk("dropped", {16'd0, drp_s}, cnt(exp_drp));
      chk("nb_accepted", {16'd0, nb_acc_s}, cnt(nb_exp_acc));
      chk("nb_dropped", {16'd0, nb_drp_s}, cnt(nb_exp_drp));
   endtask

   task automatic idle_check();
      tick();
      chk("pulse_one_cycle", {31'd0, pulse_s}, 32'd0);
      chk("nb_pulse_one_cycle", {31'd0, nb_pulse_s}, 32'd0);
   endtask

   localparam logic [47:0] UC = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BC = 48'hFF_FF_FF_FF_FF_FF;

   initial begin
      reset = 1'b1; RxValid = 1'b0; RxLast = 1'b0; RxError = 1'b0; RxData = 8'h00;
      tick(); tick();
      reset = 1'b0;
      tick();
      check_end(1'b0, 32'h0, 1'b0, 32'h0);

      // 1: unicast, 60 bytes
      build(UC, 16'h88B5, 16'h534C, 32'h0000_1000);
      send(0, 59, 1'b1, -1, 0);
      exp_acc++; nb_exp_acc++;
      check_end(1'b1, 32'h0000_1000, 1'b1, 32'h0000_1000);
      idle_check();

      // 2: broadcast; the no-broadcast instance drops it
      build(BC, 16'h88B5, 16'h534C, 32'hDEAD_BEEF);
      send(0, 59, 1'b1, -1, 0);
      exp_acc++; nb_exp_drp++;
      check_end(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000);
      idle_check();

      // 3: wrong EtherType, then wrong opcode
      build(UC, 16'h0800, 16'h534C, 32'h1111_1111);
      send(0, 59, 1'b1, -1, 0);
      exp_drp++; nb_exp_drp++;
      check_end(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000);
      build(UC, 16'h88B5, 16'h534D, 32'h2222_2222);
      send(0, 59, 1'b1, -1, 0);
      exp_drp++; nb_exp_drp++;
      check_end(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000);

      // 4: error on byte 30, then an 18-byte runt
      build(UC, 16'h88B5, 16'h534C, 32'h1234_5678);
      send(0, 59, 1'b1, 30, 0);
      exp_drp++; nb_exp_drp++;
      check_end(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000);
      send(0, 17, 1'b1, -1, 0);
      exp_drp++; nb_exp_drp++;
      check_end(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000);

      // 5: back-to-back frames, second one with 3-cycle gaps
      build(UC, 16'h88B5, 16'h534C, 32'h0000_0001);
      send(0, 59, 1'b1, -1, 0);
      exp_acc++; nb_exp_acc++;
      check_end(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0001);
      build(UC, 16'h88B5, 16'h534C, 32'h0000_0002);
      send(0, 59, 1'b1, -1, 3);
      exp_acc++; nb_exp_acc++;
      check_end(1'b1, 32'h0000_0002, 1'b1, 32'h0000_0002);
      idle_check();

      // 7: RxLast exactly on the last fill byte (20-byte frame)
      build(UC, 16'h88B5, 16'h534C, 32'h0A0B_0C0D);
      send(0, 19, 1'b1, -1, 0);
      exp_acc++; nb_exp_acc++;
      check_end(1'b1, 32'h0A0B_0C0D, 1'b1, 32'h0A0B_0C0D);
      idle_check();

      // 6: reset at byte 10, residue must be dropped, then a clean frame
      build(UC, 16'h88B5, 16'h534C, 32'h0000_0009);
      send(0, 9, 1'b0, -1, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_acc = 0; exp_drp = 0; nb_exp_acc = 0; nb_exp_drp = 0;
      check_end(1'b0, 32'h0, 1'b0, 32'h0);
      send(10, 59, 1'b1, -1, 0);
      exp_drp++; nb_exp_drp++;
      check_end(1'b0, 32'h0, 1'b0, 32'h0);
      build(UC, 16'h88B5, 16'h534C, 32'h0000_0007);
      send(0, 59, 1'b1, -1, 0);
      exp_acc++; nb_exp_acc++;
      check_end(1'b1, 32'h0000_0007, 1'b1, 32'h0000_0007);
      idle_check();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
